// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU share arbiter.
// Holds the sequencer state enum, ALU op codes and the settle counter width.
package alu_arb_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SEXT = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_RSVD = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_SLL  = 4'd10;
  localparam logic [3:0] OP_SGT  = 4'd11;
  localparam logic [3:0] OP_CLZ  = 4'd12;
  localparam logic [3:0] OP_SRL  = 4'd13;
  localparam logic [3:0] OP_SLTU = 4'd14;
  localparam logic [3:0] OP_SRA  = 4'd15;

  localparam int CNT_W = 4;

endpackage

// File: rtl/alu_arb_pick.sv
// 2-way request picker producing a one-hot grant; round-robin on last_grant by
// default, fixed port-0 priority when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_arb_pick (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = 2'b01;
`else
      // On a tie the port that did not win last time goes next.
      grant = last_grant ? 2'b01 : 2'b10;
`endif
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external ALU between two requesters: accept, hold operands for
// SETTLE_CYCLES, capture result, return it on the granted port's response handshake.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req0Valid,
  input  logic        Req1Valid,
  output logic        Req0Ready,
  output logic        Req1Ready,
  input  logic [3:0]  Req0Op,
  input  logic [3:0]  Req1Op,
  input  logic [31:0] Req0A,
  input  logic [31:0] Req0B,
  input  logic [31:0] Req1A,
  input  logic [31:0] Req1B,
  output logic        Resp0Valid,
  output logic        Resp1Valid,
  input  logic        Resp0Ready,
  input  logic        Resp1Ready,
  output logic [31:0] Resp0Result,
  output logic [31:0] Resp1Result,
  output logic        Resp0Zero,
  output logic        Resp1Zero,
  output logic        Resp0Err,
  output logic        Resp1Err,
  output logic [3:0]  AluControl,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  input  logic [31:0] AluResult,
  input  logic        AluZero
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               gnt_port;
  logic               last_grant;
  logic [31:0]        res_q;
  logic               zero_q;
  logic               err_q;
  logic [1:0]         grant;
  logic               accept;
  logic               capture;
  logic               resp_take;

  alu_arb_pick u_pick (
    .valid0     (Req0Valid),
    .valid1     (Req1Valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign Req0Ready = Rst_n && (state == IDLE) && grant[0];
  assign Req1Ready = Rst_n && (state == IDLE) && grant[1];
  assign resp_take = gnt_port ? Resp1Ready : Resp0Ready;

  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: if (Req0Ready || Req1Ready) begin
        accept    = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: if (cnt == '0) begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (resp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      AluControl <= '0;
      AluA       <= '0;
      AluB       <= '0;
      cnt        <= '0;
      gnt_port   <= 1'b0;
      last_grant <= 1'b1;
      res_q      <= '0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
      Resp0Valid <= 1'b0;
      Resp1Valid <= 1'b0;
    end else begin
      if (accept) begin
        AluControl <= grant[1] ? Req1Op : Req0Op;
        AluA       <= grant[1] ? Req1A  : Req0A;
        AluB       <= grant[1] ? Req1B  : Req0B;
        gnt_port   <= grant[1];
        last_grant <= grant[1];
        cnt        <= CNT_LOAD;
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (capture) begin
        // The reserved op still takes the full latency but never trusts the ALU.
        if (AluControl == OP_RSVD) begin
          res_q  <= '0;
          zero_q <= 1'b1;
          err_q  <= 1'b1;
        end else begin
          res_q  <= AluResult;
          zero_q <= AluZero;
          err_q  <= 1'b0;
        end
        Resp0Valid <= ~gnt_port;
        Resp1Valid <= gnt_port;
      end else if (state == RESP && resp_take) begin
        Resp0Valid <= 1'b0;
        Resp1Valid <= 1'b0;
      end
    end
  end

  assign Resp0Result = res_q;
  assign Resp1Result = res_q;
  assign Resp0Zero   = zero_q;
  assign Resp1Zero   = zero_q;
  assign Resp0Err    = err_q;
  assign Resp1Err    = err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed traffic against a time-based behavioural model
// plus literal expectations; honours ALU_ARB_FIXED_PRIO_EN for grant order.
module tb_alu_share_arb;
  import alu_arb_pkg::*;

  localparam int S = 3;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Req0Valid, Req1Valid, Req0Ready, Req1Ready;
  logic [3:0]  Req0Op, Req1Op;
  logic [31:0] Req0A, Req0B, Req1A, Req1B;
  logic        Resp0Valid, Resp1Valid, Resp0Ready, Resp1Ready;
  logic [31:0] Resp0Result, Resp1Result;
  logic        Resp0Zero, Resp1Zero, Resp0Err, Resp1Err;
  logic [3:0]  AluControl;
  logic [31:0] AluA, AluB, AluResult;
  logic        AluZero;

  int n_vec = 0;
  int n_err = 0;
  int edges = 0;
  int acc_edge = 0;
  bit chk_en = 0;

  always #5 Clk = ~Clk;

  alu_share_arb #(.SETTLE_CYCLES(S)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Req0Valid(Req0Valid), .Req1Valid(Req1Valid),
    .Req0Ready(Req0Ready), .Req1Ready(Req1Ready),
    .Req0Op(Req0Op), .Req1Op(Req1Op),
    .Req0A(Req0A), .Req0B(Req0B), .Req1A(Req1A), .Req1B(Req1B),
    .Resp0Valid(Resp0Valid), .Resp1Valid(Resp1Valid),
    .Resp0Ready(Resp0Ready), .Resp1Ready(Resp1Ready),
    .Resp0Result(Resp0Result), .Resp1Result(Resp1Result),
    .Resp0Zero(Resp0Zero), .Resp1Zero(Resp1Zero),
    .Resp0Err(Resp0Err), .Resp1Err(Resp1Err),
    .AluControl(AluControl), .AluA(AluA), .AluB(AluB),
    .AluResult(AluResult), .AluZero(AluZero)
  );

  // Stand-in ALU; op 8 returns junk so the forced result is observable.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_NOR:  return ~(a | b);
      OP_XOR:  return a ^ b;
      OP_SUB:  return a - b;
      OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
      OP_RSVD: return 32'hDEAD_BEEF;
      OP_MUL:  return a * b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SLTU: return {31'd0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  assign AluResult = alu_ref(AluControl, AluA, AluB);
  assign AluZero   = (AluResult == 32'd0);

  function automatic int pick(input logic v0, input logic v1, input bit lg);
    if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return lg ? 0 : 1;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edges);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out (edge %0d)", name, edges);
  endtask

  // Model: one op in flight; response visible from edge accept+S until consumed.
  bit          m_busy = 0;
  bit          m_lg = 1;
  int          m_port = 0;
  int          m_resp_edge = 0;
  logic [3:0]  m_ctrl = '0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic        m_zero = 0, m_err = 0;
  int          mw;

  always @(posedge Clk) begin
    edges++;
    if (!Rst_n) begin
      m_busy = 0; m_lg = 1;
      m_ctrl = '0; m_a = '0; m_b = '0;
    end else if (!m_busy) begin
      mw = pick(Req0Valid, Req1Valid, m_lg);
      if (mw >= 0) begin
        m_busy = 1;
        m_port = mw;
        m_lg = (mw == 1);
        m_resp_edge = edges + S;
        m_ctrl = (mw == 1) ? Req1Op : Req0Op;
        m_a    = (mw == 1) ? Req1A  : Req0A;
        m_b    = (mw == 1) ? Req1B  : Req0B;
        if (m_ctrl == OP_RSVD) begin
          m_res = 32'd0; m_zero = 1; m_err = 1;
        end else begin
          m_res = alu_ref(m_ctrl, m_a, m_b); m_zero = (m_res == 32'd0); m_err = 0;
        end
      end
    end else if (edges - 1 >= m_resp_edge && ((m_port == 1) ? Resp1Ready : Resp0Ready)) begin
      m_busy = 0;
    end
  end

  int cw;
  bit cev;
  always @(negedge Clk) begin
    if (chk_en) begin
      cw  = pick(Req0Valid, Req1Valid, m_lg);
      cev = m_busy && (edges >= m_resp_edge);
      chk("req0_ready", Req0Ready, Rst_n && !m_busy && cw == 0);
      chk("req1_ready", Req1Ready, Rst_n && !m_busy && cw == 1);
      chk("resp0_valid", Resp0Valid, cev && m_port == 0);
      chk("resp1_valid", Resp1Valid, cev && m_port == 1);
      if (cev) begin
        chk("resp_result", (m_port == 1) ? Resp1Result : Resp0Result, m_res);
        chk("resp_zero", (m_port == 1) ? Resp1Zero : Resp0Zero, m_zero);
        chk("resp_err", (m_port == 1) ? Resp1Err : Resp0Err, m_err);
      end
      chk("alu_ctrl", AluControl, m_ctrl);
      chk("alu_a", AluA, m_a);
      chk("alu_b", AluB, m_b);
    end
  end

  // Called just after a negedge that follows a reset edge.
  task automatic reset_vals();
    chk("rst_resp0_valid", Resp0Valid, 0);
    chk("rst_resp1_valid", Resp1Valid, 0);
    chk("rst_alu_ctrl", AluControl, 0);
    chk("rst_alu_a", AluA, 0);
    chk("rst_alu_b", AluB, 0);
    chk("rst_result", Resp0Result, 0);
    chk("rst_zero", Resp0Zero, 0);
    chk("rst_err", Resp0Err, 0);
  endtask

  // Entered at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic issue(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit done = 0;
    if (p == 0) begin Req0Valid = 1; Req0Op = op; Req0A = a; Req0B = b; end
    else        begin Req1Valid = 1; Req1Op = op; Req1A = a; Req1B = b; end
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge Clk);
      if ((p == 0 && Req0Ready) || (p == 1 && Req1Ready)) done = 1;
    end
    if (!done) timeout("issue_accept");
    @(posedge Clk);
    #1;
    acc_edge = edges;
    if (p == 0) begin Req0Valid = 0; Req0A = 32'hBAD0_BAD0; Req0Op = OP_SUB; end
    else        begin Req1Valid = 0; Req1A = 32'hBAD1_BAD1; Req1Op = OP_SUB; end
  endtask

  // Returns at the negedge where the response is first seen.
  task automatic wait_resp(input int p, input logic [31:0] res, input logic z, input logic e);
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge Clk);
      if ((p == 0 && Resp0Valid) || (p == 1 && Resp1Valid)) done = 1;
    end
    if (!done) begin
      timeout("resp_valid");
    end else begin
      chk("lit_latency", edges - acc_edge, S);
      chk("lit_result", (p == 1) ? Resp1Result : Resp0Result, res);
      chk("lit_zero", (p == 1) ? Resp1Zero : Resp0Zero, z);
      chk("lit_err", (p == 1) ? Resp1Err : Resp0Err, e);
      chk("lit_other_valid", (p == 1) ? Resp0Valid : Resp1Valid, 0);
    end
  endtask

  initial begin
    int g;
    bit seen;
    Rst_n = 0;
    Req0Valid = 1; Req1Valid = 1;
    Req0Op = OP_ADD; Req1Op = OP_ADD;
    Req0A = 0; Req0B = 0; Req1A = 0; Req1B = 0;
    Resp0Ready = 1; Resp1Ready = 1;
    @(posedge Clk); @(posedge Clk); #1;
    chk_en = 1;
    @(negedge Clk);
    chk("rst_req0_ready", Req0Ready, 0);
    chk("rst_req1_ready", Req1Ready, 0);
    reset_vals();
    @(posedge Clk); #1;
    Req0Valid = 0; Req1Valid = 0; Rst_n = 1;

    // ADD 5+7 on port 0
    issue(0, OP_ADD, 32'd5, 32'd7);
    wait_resp(0, 32'd12, 1'b0, 1'b0);
    @(posedge Clk); #1;

    // SUB 9-9 on port 1
    issue(1, OP_SUB, 32'd9, 32'd9);
    wait_resp(1, 32'd0, 1'b1, 1'b0);
    @(posedge Clk); #1;

    // Fresh reset, then both ports request continuously for six grants
    Rst_n = 0;
    @(posedge Clk); #1;
    Rst_n = 1;
    Req0Valid = 1; Req0Op = OP_ADD; Req0A = 32'd100; Req0B = 32'd1;
    Req1Valid = 1; Req1Op = OP_SUB; Req1A = 32'd50;  Req1B = 32'd8;
    for (int k = 0; k < 6; k++) begin
      seen = 0;
      g = -1;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge Clk);
        if (Req0Ready || Req1Ready) begin seen = 1; g = Req1Ready ? 1 : 0; end
      end
      if (!seen) timeout("grant_wait");
`ifdef ALU_ARB_FIXED_PRIO_EN
      else chk("grant_order", g, 0);
`else
      else chk("grant_order", g, k % 2);
`endif
      @(posedge Clk); #1;
    end
    Req0Valid = 0; Req1Valid = 0;
    for (int i = 0; i < S + 3; i++) @(posedge Clk);
    #1;

    // SLT with a stalled consumer while port 1 waits
    Resp0Ready = 0;
    issue(0, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    Req1Valid = 1; Req1Op = OP_ADD; Req1A = 32'd10; Req1B = 32'd20;
    wait_resp(0, 32'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("hold_valid", Resp0Valid, 1);
      chk("hold_result", Resp0Result, 32'd1);
      chk("hold_req1_ready", Req1Ready, 0);
    end
    @(posedge Clk); #1;
    Resp0Ready = 1;
    issue(1, OP_ADD, 32'd10, 32'd20);
    wait_resp(1, 32'd30, 1'b0, 1'b0);
    @(posedge Clk); #1;

    // Reserved op on port 1
    issue(1, OP_RSVD, 32'd7, 32'd9);
    wait_resp(1, 32'd0, 1'b1, 1'b1);
    @(posedge Clk); #1;

    // MUL aborted by reset mid-EXEC, then reissued
    issue(0, OP_MUL, 32'd3, 32'd4);
    @(posedge Clk); #1;
    Rst_n = 0;
    @(posedge Clk); #1;
    Rst_n = 1;
    @(negedge Clk);
    reset_vals();
    for (int i = 0; i < S + 4; i++) begin
      @(negedge Clk);
      chk("abort_resp0", Resp0Valid, 0);
      chk("abort_resp1", Resp1Valid, 0);
    end
    @(posedge Clk); #1;
    issue(0, OP_MUL, 32'd3, 32'd4);
    wait_resp(0, 32'd12, 1'b0, 1'b0);
    @(posedge Clk); #1;
    for (int i = 0; i < 3; i++) @(posedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and sequencer that shares one ALU32Bit instance between two requesters, such as the execute stage and a multi-cycle helper unit. It accepts one operation at a time over a valid/ready handshake and drives the ALU's ALUControl/A/B from registers. It waits a configurable number of settle cycles, captures ALUResult/Zero, and returns them on a per-port response handshake. It sits between the requesters and the single ALU instance, which it wires to directly.

## Interface
Parameters:
- SETTLE_CYCLES, 1: cycles operands are held on the ALU before capture; legal range 1..15.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rst_n  in  1  reset, synchronous and active-low.
- Req0Valid / Req1Valid  in  1  request present on port N.
- Req0Ready / Req1Ready  out  1  port N request accepted this cycle.
- Req0Op / Req1Op  in  4  ALU control code for port N.
- Req0A, Req0B / Req1A, Req1B  in  32  operands for port N.
- Resp0Valid / Resp1Valid  out  1  result available for port N.
- Resp0Ready / Resp1Ready  in  1  port N consumes its result.
- Resp0Result / Resp1Result  out  32  captured ALU result.
- Resp0Zero / Resp1Zero  out  1  captured Zero flag.
- Resp0Err / Resp1Err  out  1  high when the op was the reserved code 8.
- AluControl  out  4  to ALU ALUControl.
- AluA, AluB  out  32  to ALU A and B.
- AluResult  in  32  from ALU ALUResult.
- AluZero  in  1  from ALU Zero.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Pick a winner among asserted ReqNValid.
  - Assert ReqNReady for the winner only. Valid&Ready is the accept.
  - On accept: register Op/A/B onto AluControl/AluA/AluB, record the granted port, load the counter with SETTLE_CYCLES-1, go to EXEC.
- Arbitration is round-robin on a 1-bit LastGrant.
  - Single requester wins outright.
  - On a tie, the port not equal to LastGrant wins.
  - LastGrant updates only on accept.
- EXEC:
  - ALU inputs stay stable.
  - Counter decrements each cycle.
  - In the cycle the counter reads 0: capture AluResult/AluZero into the result register, go to RESP.
- Op 8 (reserved):
  - Accepted and sequenced with the same latency.
  - Captured Result is forced to 0 and Zero to 1.
  - Err is set.
- RESP:
  - RespNValid is high for the granted port only; the other port's RespValid stays 0.
  - Result/Zero/Err are held stable until RespNReady. On RespNReady, go to IDLE.
- A requester may drop Valid before accept with no effect. Op/A/B are sampled only at accept.
- AluControl/AluA/AluB hold their last issued values outside EXEC; they are not re-driven.
- Reset:
  - Asserting Rst_n low during EXEC or RESP aborts the in-flight op. No response is produced.
  - Reset values: state IDLE; all ReqNReady/RespNValid 0; AluControl 0, AluA 0, AluB 0; results 0, Zero 0, Err 0; counter 0; LastGrant 1, so port 0 wins the first tie.
  - ReqNReady is forced 0 while Rst_n is low.

## Timing
- Accept at edge t. EXEC spans cycles t+1 .. t+SETTLE_CYCLES. RespNValid rises in cycle t+1+SETTLE_CYCLES.
- Latency from accept to response valid = 1+SETTLE_CYCLES cycles.
- If RespNReady is high in the first RESP cycle, the state is IDLE the next cycle. The next accept can happen in that IDLE cycle.
- Peak throughput is one op per 2+SETTLE_CYCLES cycles. There is no back-to-back overlap.
- ReqNReady is combinational from state, ReqValid and LastGrant. All other outputs are registered.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: port 0 always wins ties and LastGrant is unused. Port 1 can starve; this mode is intended for execute-stage-first pipelines.
- ALU_ARB_FIXED_PRIO_EN undefined: round-robin as described above.

## Structure
- Package alu_arb_pkg holds:
  - the state enum {IDLE, EXEC, RESP};
  - ALU op localparams: AND 0, OR 1, ADD 2, NOR 3, XOR 4, SEXT 5, SUB 6, SLT 7, RSVD 8, MUL 9, SLL 10, SGT 11, CLZ 12, SRL 13, SLTU 14, SRA 15;
  - the counter width (4).
- Sub-module alu_arb_pick is the 2-way picker: inputs are the two valids and LastGrant, output is a one-hot grant. The macro is honoured inside it.

## Test plan
- Port 0 ADD 5+7, SETTLE_CYCLES=1, Resp0Ready tied high -> Resp0Valid in cycle accept+2 with Result 12, Zero 0. Resp1Valid stays 0.
- Port 1 SUB 9-9 -> Result 0, Zero 1. After out of reset, both ports request in the same cycle -> port 0 is granted first, then port 1.
- Both ports request continuously for 6 ops -> grants alternate 0,1,0,1,0,1. With ALU_ARB_FIXED_PRIO_EN defined -> all grants go to port 0.
- Port 0 SLT A=0xFFFFFFFF, B=1, Resp0Ready held low for 5 cycles -> Result 1 held stable with Resp0Valid high the whole time. Req1Ready stays 0 until the RESP exit.
- Port 1 Op 8 -> Result 0, Zero 1, Err 1, with normal latency.
- MUL 3*4 with SETTLE_CYCLES=4, Rst_n pulsed low during EXEC -> no response; all outputs at reset values; the next request completes normally with Result 12.
